// File: rtl/led_display_pkg.sv
// led_display_pkg: shared types and width helpers for the LED display frame path
package led_display_pkg;

    typedef logic [2:0] rgb_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_TOP,
        S_FETCH_BOT,
        S_WAIT,
        S_PRESENT
    } scan_state_t;

    // index width for a count of n items, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_display_dp_ram.sv
// led_display_dp_ram: simple dual-port RAM, synchronous write, registered read
module led_display_dp_ram #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // no reset on the array or read register so the store maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/led_display_frame_scanner.sv
// led_display_frame_scanner: double-buffered frame store streaming top/bottom pixel pairs in scan order
module led_display_frame_scanner
    import led_display_pkg::*;
#(
    parameter  int NUM_ROW_PIXELS = 32,
    parameter  int NUM_COL_PIXELS = 64,
    localparam int COL_W          = idx_width(NUM_COL_PIXELS),
    localparam int ROW_W          = idx_width(NUM_ROW_PIXELS),
    localparam int SCAN_W         = ROW_W - 1
) (
    input  logic              clk_in,
    input  logic              n_reset_in,
    input  logic              wr_valid_in,
    output logic              wr_ready_out,
    input  logic [COL_W-1:0]  wr_x_in,
    input  logic [ROW_W-1:0]  wr_y_in,
    input  logic [2:0]        wr_rgb_in,
    input  logic              frame_commit_in,
    output logic              commit_pending_out,
    output logic              pix_valid_out,
    input  logic              pix_ready_in,
    output logic [2:0]        pix_rgb_top_out,
    output logic [2:0]        pix_rgb_bot_out,
    output logic [COL_W-1:0]  pix_col_out,
    output logic [SCAN_W-1:0] pix_row_out,
    output logic              pix_eol_out,
    output logic              pix_eof_out
);

    localparam int ADDR_W = 1 + ROW_W + COL_W;

    scan_state_t       state_q, state_d;
    logic              alive_q, front_q, front_valid_q, pending_q;
    logic [COL_W-1:0]  col_q;
    logic [SCAN_W-1:0] row_q;
    rgb_t              top_q, bot_q, rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_fire, pix_fire;

    assign wr_ready_out       = alive_q && !pending_q;
    assign wr_fire            = wr_valid_in && wr_ready_out;
    assign commit_pending_out = pending_q;
    assign pix_valid_out      = state_q == S_PRESENT;
    assign pix_fire           = pix_valid_out && pix_ready_in;
    assign pix_col_out        = col_q;
    assign pix_row_out        = row_q;
    assign pix_eol_out        = &col_q;
    assign pix_eof_out        = pix_eol_out && (&row_q);
    assign pix_rgb_top_out    = front_valid_q ? top_q : 3'b000;
    assign pix_rgb_bot_out    = front_valid_q ? bot_q : 3'b000;
    // bottom half row is the scan row with the half-select bit set
    assign rd_addr            = {front_q, state_q != S_FETCH_TOP, row_q, col_q};

    led_display_dp_ram #(.DATA_W(3), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk_in),
        .wr_en   (wr_fire),
        .wr_addr ({~front_q, wr_y_in, wr_x_in}),
        .wr_data (wr_rgb_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // scan state register
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // fetch top, fetch bottom, wait for bottom data, then present until consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH_TOP;
            S_FETCH_TOP: state_d = S_FETCH_BOT;
            S_FETCH_BOT: state_d = S_WAIT;
            S_WAIT:      state_d = S_PRESENT;
            S_PRESENT:   state_d = pix_ready_in ? S_FETCH_TOP : S_PRESENT;
            default:     state_d = S_IDLE;
        endcase
    end

    // pixel latches, scan counters, and bank swap taken only on the end-of-frame handshake
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            alive_q       <= 1'b0;
            front_q       <= 1'b0;
            front_valid_q <= 1'b0;
            pending_q     <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            top_q         <= '0;
            bot_q         <= '0;
        end else begin
            alive_q <= 1'b1;
            if (state_q == S_FETCH_BOT) top_q <= rd_data;
            if (state_q == S_WAIT) bot_q <= rd_data;
            if (pix_fire) begin
                col_q <= col_q + 1'b1;
                if (pix_eol_out) row_q <= row_q + 1'b1;
            end
            if (pix_fire && pix_eof_out && pending_q) begin
                front_q       <= ~front_q;
                front_valid_q <= 1'b1;
                pending_q     <= 1'b0;
            end else if (frame_commit_in) begin
                pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_display_frame_scanner.sv
// tb_led_display_frame_scanner: scoreboard bench for the double-buffered frame scanner
module tb_led_display_frame_scanner;

    localparam int NR    = 32;
    localparam int NC    = 64;
    localparam int HALF  = NR / 2;
    localparam int PAIRS = HALF * NC;

    typedef struct {
        int row;
        int col;
        int top;
        int bot;
        int eol;
        int eof;
    } pair_t;

    logic       clk_in = 1'b0;
    logic       n_reset_in = 1'b1;
    logic       wr_valid_in = 1'b0;
    logic       wr_ready_out;
    logic [5:0] wr_x_in = '0;
    logic [4:0] wr_y_in = '0;
    logic [2:0] wr_rgb_in = '0;
    logic       frame_commit_in = 1'b0;
    logic       commit_pending_out;
    logic       pix_valid_out;
    logic       pix_ready_in = 1'b0;
    logic [2:0] pix_rgb_top_out, pix_rgb_bot_out;
    logic [5:0] pix_col_out;
    logic [3:0] pix_row_out;
    logic       pix_eol_out, pix_eof_out;

    led_display_frame_scanner dut (
        .clk_in             (clk_in),
        .n_reset_in         (n_reset_in),
        .wr_valid_in        (wr_valid_in),
        .wr_ready_out       (wr_ready_out),
        .wr_x_in            (wr_x_in),
        .wr_y_in            (wr_y_in),
        .wr_rgb_in          (wr_rgb_in),
        .frame_commit_in    (frame_commit_in),
        .commit_pending_out (commit_pending_out),
        .pix_valid_out      (pix_valid_out),
        .pix_ready_in       (pix_ready_in),
        .pix_rgb_top_out    (pix_rgb_top_out),
        .pix_rgb_bot_out    (pix_rgb_bot_out),
        .pix_col_out        (pix_col_out),
        .pix_row_out        (pix_row_out),
        .pix_eol_out        (pix_eol_out),
        .pix_eof_out        (pix_eof_out)
    );

    always #5 clk_in = ~clk_in;

    pair_t    exp_q[$];
    pair_t    cur;
    bit       have_cur;
    bit [2:0] m_mem[2][NR][NC];
    bit       m_known[2][NR][NC];
    bit       m_alive;
    int       m_front, m_fv, m_pending, m_row, m_col;
    int       frames, pair_cnt;
    int       ready_pct = 100;
    int       n_checks, n_pass;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // expected pair at a scan position from the bench's own bank model; -1 marks never-written RAM
    function automatic pair_t exp_pair(input int r, input int c);
        pair_t p;
        p.row = r;
        p.col = c;
        p.eol = int'(c == NC - 1);
        p.eof = int'(c == NC - 1 && r == HALF - 1);
        p.top = !m_fv ? 0 : m_known[m_front][r][c] ? int'(m_mem[m_front][r][c]) : -1;
        p.bot = !m_fv ? 0 : m_known[m_front][r+HALF][c] ? int'(m_mem[m_front][r+HALF][c]) : -1;
        return p;
    endfunction

    always @(posedge clk_in or negedge n_reset_in) m_alive <= n_reset_in;

    // monitor: drives pix_ready, scores pairs, tracks write/commit/swap in the model
    initial begin
        bit prev_stall, hs;
        int old_pend, b;
        prev_stall = 0;
        forever begin
            @(negedge clk_in);
            if (!n_reset_in) begin
                exp_q.delete();
                have_cur   = 0;
                m_front    = 0;
                m_fv       = 0;
                m_pending  = 0;
                m_row      = 0;
                m_col      = 0;
                pair_cnt   = 0;
                prev_stall = 0;
                exp_q.push_back(exp_pair(0, 0));
            end else begin
                check("wr_ready", wr_ready_out, int'(m_alive && m_pending == 0));
                check("pending", commit_pending_out, m_pending);
                if (prev_stall) check("valid_held", pix_valid_out, 1);
                if (pix_valid_out) begin
                    if (!have_cur) begin
                        check("queue_has_entry", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            cur      = exp_q.pop_front();
                            have_cur = 1;
                        end
                    end
                    if (have_cur) begin
                        check("row", pix_row_out, cur.row);
                        check("col", pix_col_out, cur.col);
                        check("eol", pix_eol_out, cur.eol);
                        check("eof", pix_eof_out, cur.eof);
                        if (cur.top >= 0) check("rgb_top", pix_rgb_top_out, cur.top);
                        if (cur.bot >= 0) check("rgb_bot", pix_rgb_bot_out, cur.bot);
                    end
                end
                pix_ready_in = ($urandom_range(99) < ready_pct);
                hs           = pix_valid_out && pix_ready_in;
                prev_stall   = pix_valid_out && !pix_ready_in;
                old_pend     = m_pending;
                if (wr_valid_in && m_alive && old_pend == 0) begin
                    b = 1 - m_front;
                    m_mem[b][wr_y_in][wr_x_in]   = wr_rgb_in;
                    m_known[b][wr_y_in][wr_x_in] = 1;
                end
                if (hs && have_cur) begin
                    pair_cnt++;
                    if (cur.eof) begin
                        check("pairs_per_frame", pair_cnt, PAIRS);
                        pair_cnt = 0;
                        frames++;
                        if (old_pend != 0) begin
                            m_front   = 1 - m_front;
                            m_fv      = 1;
                            m_pending = 0;
                        end
                    end
                    m_col = (m_col + 1) % NC;
                    if (m_col == 0) m_row = (m_row + 1) % HALF;
                    exp_q.push_back(exp_pair(m_row, m_col));
                    have_cur = 0;
                end
                if (frame_commit_in && old_pend == 0) m_pending = 1;
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, pix_valid_out, 0);
        check({tag, "_top"}, pix_rgb_top_out, 0);
        check({tag, "_bot"}, pix_rgb_bot_out, 0);
        check({tag, "_col"}, pix_col_out, 0);
        check({tag, "_row"}, pix_row_out, 0);
        check({tag, "_eol"}, pix_eol_out, 0);
        check({tag, "_eof"}, pix_eof_out, 0);
        check({tag, "_wr_ready"}, wr_ready_out, 0);
        check({tag, "_pending"}, commit_pending_out, 0);
    endtask

    task automatic wait_frames(input int n);
        int target, cnt;
        target = frames + n;
        cnt    = 0;
        while (frames < target && cnt < 9000 * n) begin
            @(posedge clk_in); #1;
            cnt++;
        end
        check("frame_arrived", int'(frames >= target), 1);
    endtask

    task automatic wait_row(input int r);
        int cnt;
        cnt = 0;
        while (!(pix_valid_out && pix_row_out == 4'(r)) && cnt < 9000) begin
            @(posedge clk_in); #1;
            cnt++;
        end
        check("row_reached", pix_row_out, r);
    endtask

    task automatic wait_wr_ready();
        int cnt;
        cnt = 0;
        while (!wr_ready_out && cnt < 20000) begin
            @(posedge clk_in); #1;
            cnt++;
        end
        check("wr_ready_seen", wr_ready_out, 1);
    endtask

    task automatic do_write(input int x, input int y, input int rgb);
        wait_wr_ready();
        wr_x_in     = 6'(x);
        wr_y_in     = 5'(y);
        wr_rgb_in   = 3'(rgb);
        wr_valid_in = 1'b1;
        @(posedge clk_in); #1;
        wr_valid_in = 1'b0;
    endtask

    task automatic do_commit();
        frame_commit_in = 1'b1;
        @(posedge clk_in); #1;
        frame_commit_in = 1'b0;
    endtask

    initial begin
        #2 n_reset_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 check_idle("reset");
        n_reset_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk_in); #1;
            check("first_valid_latency", pix_valid_out, int'(k == 4));
        end
        wait_frames(1);

        do_write(5, 3, 3'b101);
        do_write(5, 19, 3'b010);
        do_commit();
        wait_frames(2);

        wait_row(7);
        do_commit();
        check("mid_commit_pending", commit_pending_out, 1);
        check("mid_commit_stall", wr_ready_out, 0);
        wait_frames(1);
        check("swap_clears_pending", commit_pending_out, 0);

        ready_pct = 70;
        for (int i = 0; i < 24; i++)
            do_write($urandom_range(NC - 1), $urandom_range(NR - 1), $urandom_range(7));
        do_commit();
        wait_frames(2);

        wait_wr_ready();
        wr_x_in         = 6'd10;
        wr_y_in         = 5'd20;
        wr_rgb_in       = 3'b111;
        wr_valid_in     = 1'b1;
        frame_commit_in = 1'b1;
        @(posedge clk_in); #1;
        wr_valid_in = 1'b0;
        @(posedge clk_in); #1;
        frame_commit_in = 1'b0;
        check("double_commit_pending", commit_pending_out, 1);
        wait_frames(2);

        wait_row(9);
        n_reset_in = 1'b0;
        #1 check_idle("mid_reset");
        repeat (2) @(posedge clk_in);
        #1 n_reset_in = 1'b1;
        wait_frames(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
